// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-ported RAM between the instruction-fetch and data ports.
// Define LLSC_EN to build the LinkedLoad/StoreConditional link register.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              ll,
  input  logic              sc,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
);

  localparam int unsigned STREAK_W = $clog2(MAX_DSTREAK + 1);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                ram_ren_q, ram_ren_d;
  logic                ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_store_q, ram_store_d;
  logic [DATA_W-1:0]   iload_q, iload_d;
  logic [DATA_W-1:0]   dload_q, dload_d;
  logic                iwait_q, iwait_d;
  logic                dwait_q, dwait_d;
  logic                sc_q, sc_d;
  logic                d_req;
  logic                i_forced;

`ifdef LLSC_EN
  logic                ll_q, ll_d;
  logic                sc_fail_q, sc_fail_d;
  logic                link_valid_q, link_valid_d;
  logic [ADDR_W-1:0]   link_addr_q, link_addr_d;
`else
  logic                unused_ll;
  assign unused_ll = ll;
`endif

  assign d_req    = dREN | dWEN;
  assign i_forced = iREN & (streak_q == STREAK_W'(MAX_DSTREAK));

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;
    iload_d     = iload_q;
    dload_d     = dload_q;
    iwait_d     = iwait_q;
    dwait_d     = dwait_q;
    sc_d        = sc_q;
`ifdef LLSC_EN
    ll_d         = ll_q;
    sc_fail_d    = sc_fail_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req && !i_forced) begin
          state_d     = GRANT_D;
          streak_d    = !iREN ? '0 :
                        (streak_q == STREAK_W'(MAX_DSTREAK)) ? streak_q : streak_q + STREAK_W'(1);
          ram_ren_d   = dREN;
          ram_wen_d   = dWEN;
          ram_addr_d  = daddr;
          ram_store_d = dWEN ? dstore : ram_store_q;
          sc_d        = dWEN & sc;
`ifdef LLSC_EN
          ll_d = dREN & ll;
          if (dWEN && sc) begin
            // A failed SC never touches the RAM
            if (!(link_valid_q && (daddr == link_addr_q))) begin
              ram_wen_d = 1'b0;
              sc_fail_d = 1'b1;
            end
            link_valid_d = 1'b0;
          end else if (dWEN && (daddr == link_addr_q)) begin
            link_valid_d = 1'b0;
          end
`endif
        end else if (iREN) begin
          state_d    = GRANT_I;
          streak_d   = '0;
          ram_ren_d  = 1'b1;
          ram_wen_d  = 1'b0;
          ram_addr_d = iaddr;
        end
      end
      GRANT_I: begin
        if (ram_ready) begin
          state_d   = RESP;
          ram_ren_d = 1'b0;
          iload_d   = ramload;
          iwait_d   = 1'b0;
        end
      end
      GRANT_D: begin
`ifdef LLSC_EN
        if (sc_fail_q) begin
          state_d   = RESP;
          sc_fail_d = 1'b0;
          dload_d   = '0;
          dwait_d   = 1'b0;
        end else
`endif
        if (ram_ready) begin
          state_d   = RESP;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          dwait_d   = 1'b0;
          dload_d   = ram_wen_q ? DATA_W'(sc_q) : ramload;
`ifdef LLSC_EN
          if (ll_q) begin
            link_addr_d  = ram_addr_q;
            link_valid_d = 1'b1;
          end
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
        iwait_d = 1'b1;
        dwait_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
      iload_q     <= '0;
      dload_q     <= '0;
      iwait_q     <= 1'b1;
      dwait_q     <= 1'b1;
      sc_q        <= 1'b0;
`ifdef LLSC_EN
      ll_q         <= 1'b0;
      sc_fail_q    <= 1'b0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
      iload_q     <= iload_d;
      dload_q     <= dload_d;
      iwait_q     <= iwait_d;
      dwait_q     <= dwait_d;
      sc_q        <= sc_d;
`ifdef LLSC_EN
      ll_q         <= ll_d;
      sc_fail_q    <= sc_fail_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
`endif
    end
  end

  assign iload    = iload_q;
  assign dload    = dload_q;
  assign iwait    = iwait_q;
  assign dwait    = dwait_q;
  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = ram_addr_q;
  assign ramstore = ram_store_q;

endmodule
